fp_div_issue_seq: RTL and testbench
===================================

# fp_div_issue_seq

Operand-queueing issue sequencer that sits directly upstream of the pipelined fixed-point divider (`std_fp_div_pipe` family, WIDTH=32, INT_WIDTH=1, FRAC_WIDTH=31). It accepts dividend/divisor pairs on a valid/ready stream and buffers them in a small FIFO. It drives the divider's `go`/`left`/`right` one operation at a time, then captures quotient and remainder on `done` into a valid/ready output register. The divider itself is not instantiated here; this block connects to it through the `div_*` ports.

## Interface
- `WIDTH`, 32: operand and result width; must equal the divider's WIDTH.
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.

- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high. Shared with the divider.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: FIFO can accept; `!full`.
- `in_left` input WIDTH: dividend.
- `in_right` input WIDTH: divisor.
- `div_go` output 1: divider go.
- `div_left` output WIDTH: divider dividend, driven from the FIFO head.
- `div_right` output WIDTH: divider divisor, driven from the FIFO head.
- `div_quotient` input WIDTH: divider `out_quotient`.
- `div_remainder` input WIDTH: divider `out_remainder`.
- `div_done` input 1: divider done pulse.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts.
- `out_quotient` output WIDTH: captured quotient.
- `out_remainder` output WIDTH: captured remainder.
- `out_err` output 1: divide-by-zero flag (see Configuration).
- `count` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO.**
  - Push on `in_valid && in_ready`.
  - Pop when the head operation completes, on the cycle `div_done` is high in RUN, or on the cycle of a BYPASS.
  - No full-bypass: with a full FIFO, `in_ready=0` even if a pop happens the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states.** IDLE, RUN, and BYPASS (BYPASS only with the macro).
  - IDLE → RUN when FIFO non-empty and (`!out_valid` || `out_ready`).
  - RUN → IDLE on `div_done`: capture `div_quotient`/`div_remainder` into the output register, set `out_valid=1`, `out_err=0`, pop the FIFO.
  - RUN never exits otherwise.
- **`div_go` rule.** `div_go = (state==RUN) && !div_done && !reset`, combinational. The divider restarts if go is still high on its done cycle, so go must drop in that same cycle.
- **Operand stability.** `div_left`/`div_right` are the FIFO head and stay stable throughout RUN.
- **Output register.**
  - `out_valid` clears on `out_ready && out_valid` unless a capture happens the same cycle. Capture takes priority and overwrites.
  - Capture is guaranteed non-blocking, because RUN is only entered when the register is free or draining.
- **Zero dividend.** No special case here; the divider returns done one cycle after go with zeros, and those zeros are forwarded.
- **Reset values.**
  - `out_valid=0`, `out_quotient=0`, `out_remainder=0`, `out_err=0`, `count=0`.
  - `in_ready=1`, state IDLE, `div_go=0`.
- **Reset mid-RUN.** The in-flight operation and all FIFO contents are discarded, with no output produced.

## Timing
- Push to visible occupancy: 1 cycle.
- IDLE → RUN: 1 cycle after the FIFO becomes non-empty with the output free. `div_go` is high from the first RUN cycle.
- `out_valid` rises the cycle after `div_done`.
- Zero dividend: first `div_go` cycle N, `div_done` at N+1, `out_valid` at N+2.
- Back-to-back throughput: when the output is drained immediately, the next RUN begins 1 cycle after capture, so IDLE lasts one cycle between operations.
- `div_done` outside RUN is ignored.

## Configuration
- **`FP_DIV_ZERO_CHK_EN` defined.**
  - In IDLE, a head with `div_right==0` (and the output free) goes to BYPASS instead of RUN. `div_go` stays 0.
  - BYPASS lasts one cycle, then → IDLE. It loads `out_quotient={WIDTH{1'b1}}`, `out_remainder=head left`, `out_err=1`, `out_valid=1`, and pops the FIFO.
  - `out_valid` rises 2 cycles after IDLE sees the head.
- **Not defined.**
  - Zero divisors are issued to the divider like any other operation; the result is whatever the divider produces.
  - `out_err` is tied to 0 and the BYPASS state does not exist.

## Test plan
- Reset, then push left=0x20000000, right=0x40000000 (0.25/0.5), with `out_ready` held 1.
  - Exactly one `div_go` episode, with `div_left`/`div_right` stable throughout.
  - Then `out_valid` for one cycle with `out_quotient=0x40000000`, `out_err=0`.
- Push 5 pairs back-to-back with DEPTH=4.
  - `in_ready` drops after the 4th accept.
  - Results come out in order, `count` never exceeds 4, and there is no wrap-around corruption.
- Push left=0, right=0x40000000.
  - `div_done` arrives the cycle after go.
  - `out_valid` arrives 2 cycles after go, with quotient=0 and remainder=0.
- Hold `out_ready=0` with 2 queued ops.
  - The first result is held stable and no second `div_go` occurs.
  - After `out_ready=1` for one cycle, the second op issues the next cycle.
- Assert `reset` mid-RUN with 3 entries queued.
  - `div_go=0` in the reset cycle, then `count=0`, `out_valid=0`, and no stray capture occurs when a late `div_done` arrives.
- With `FP_DIV_ZERO_CHK_EN`, push left=0x12345678, right=0.
  - No `div_go`, then `out_valid` with quotient=0xFFFFFFFF, remainder=0x12345678, `out_err=1`.
  - Without the macro, the same stimulus issues `div_go`.

Source files
------------

// File: rtl/fp_div_issue_seq.sv
// Issue sequencer for a pipelined fixed-point divider: buffers operand pairs and issues them one at a time.
// Optional zero-divisor short-circuit enabled by defining FP_DIV_ZERO_CHK_EN.
module fp_div_issue_seq #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_left,
  input  logic [WIDTH-1:0]       in_right,
  output logic                   div_go,
  output logic [WIDTH-1:0]       div_left,
  output logic [WIDTH-1:0]       div_right,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder,
  input  logic                   div_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_quotient,
  output logic [WIDTH-1:0]       out_remainder,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

`ifdef FP_DIV_ZERO_CHK_EN
  typedef enum logic [1:0] {IDLE, RUN, BYPASS} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] fifo_left  [DEPTH];
  logic [WIDTH-1:0] fifo_right [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             capture;
  logic             out_free;
  logic             nonempty;
`ifdef FP_DIV_ZERO_CHK_EN
  logic             bypass_load;
`endif

  // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign nonempty = (count != '0);
  assign out_free = !out_valid || out_ready;
  assign div_left  = fifo_left[rd_ptr];
  assign div_right = fifo_right[rd_ptr];

  // Go must fall in the done cycle itself, otherwise the divider restarts.
  assign div_go = (state == RUN) && !div_done && !reset;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_left[wr_ptr]  <= in_left;
      fifo_right[wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Issue only when the output register is free or draining, so a capture never has to stall.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
`ifdef FP_DIV_ZERO_CHK_EN
    bypass_load = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef FP_DIV_ZERO_CHK_EN
        if (nonempty && out_free) state_next = (div_right == '0) ? BYPASS : RUN;
`else
        if (nonempty && out_free) state_next = RUN;
`endif
      end
      RUN: begin
        if (div_done) begin
          state_next = IDLE;
          pop        = 1'b1;
          capture    = 1'b1;
        end
      end
`ifdef FP_DIV_ZERO_CHK_EN
      BYPASS: begin
        state_next  = IDLE;
        pop         = 1'b1;
        bypass_load = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_quotient  <= div_quotient;
      out_remainder <= div_remainder;
`ifdef FP_DIV_ZERO_CHK_EN
    end else if (bypass_load) begin
      out_valid     <= 1'b1;
      out_quotient  <= '1;
      out_remainder <= div_left;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FP_DIV_ZERO_CHK_EN
  always_ff @(posedge clk) begin
    if (reset)            out_err <= 1'b0;
    else if (capture)     out_err <= 1'b0;
    else if (bypass_load) out_err <= 1'b1;
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_div_issue_seq.sv
// Scoreboard bench for fp_div_issue_seq with a behavioural Q1.31 divider model on the div_* ports.
module tb_fp_div_issue_seq;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_left;
  logic [31:0] in_right;
  logic        div_go;
  logic [31:0] div_left;
  logic [31:0] div_right;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_err;
  logic [2:0]  count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   out_count = 0;
  int   go_episodes = 0;
  int   stab_err = 0;
  int   hold_err = 0;
  int   max_count = 0;

  always #5 clk = ~clk;

  fp_div_issue_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .div_go(div_go), .div_left(div_left), .div_right(div_right),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_err(out_err),
    .count(count)
  );

  // Divider model: multi-cycle latency, one-cycle done for a zero dividend.
  logic        model_done;
  logic        stray_done;
  logic [31:0] model_q;
  logic [31:0] model_r;
  logic [31:0] m_left;
  logic [31:0] m_right;
  logic        m_busy;
  int          m_cnt;

  assign div_done      = model_done | stray_done;
  assign div_quotient  = model_q;
  assign div_remainder = model_r;

  function automatic logic [63:0] ref_div(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] num;
    num = {1'b0, l, 31'b0};
    if (r == 32'h0) return {32'hFFFFFFFF, l};
    return {32'(num / {32'h0, r}), 32'(num % {32'h0, r})};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      model_done <= 1'b0;
      model_q    <= '0;
      model_r    <= '0;
    end else begin
      model_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          model_done         <= 1'b1;
          m_busy             <= 1'b0;
          {model_q, model_r} <= ref_div(m_left, m_right);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (div_go && !model_done) begin
        if (div_left == 32'h0) begin
          model_done <= 1'b1;
          model_q    <= '0;
          model_r    <= '0;
        end else begin
          m_busy  <= 1'b1;
          m_cnt   <= 3;
          m_left  <= div_left;
          m_right <= div_right;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: scoreboard pops on every output handshake, plus go-episode and hold tracking.
  logic        prev_go = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_taken = 1'b0;
  logic [31:0] go_l;
  logic [31:0] go_r;
  logic [31:0] hold_q;
  logic [31:0] hold_r;

  always @(negedge clk) begin
    exp_t e;
    if (int'(count) > max_count) max_count = int'(count);
    if (div_go && !prev_go) begin
      go_episodes++;
      go_l = div_left;
      go_r = div_right;
    end else if (div_go && (div_left !== go_l || div_right !== go_r)) begin
      stab_err++;
    end
    if (out_valid && prev_valid && !prev_taken &&
        (out_quotient !== hold_q || out_remainder !== hold_r)) hold_err++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got quotient 0x%08h, expected no output", out_quotient);
      end else begin
        e = sb.pop_front();
        check_output("quotient", out_quotient, e.q);
        check_output("remainder", out_remainder, e.r);
        check_output("err", 32'(out_err), 32'(e.err));
      end
      out_count++;
    end
    prev_go    = div_go;
    prev_valid = out_valid;
    prev_taken = out_valid && out_ready;
    hold_q     = out_quotient;
    hold_r     = out_remainder;
  end

  task automatic apply_stimulus(input logic [31:0] l, input logic [31:0] r, input bit record,
                                input logic [31:0] eq, input logic [31:0] er, input logic ee);
    bit ok;
    bit accepted;
    exp_t e;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (int i = 0; i < 100; i++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        accepted = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check_output("push_accepted", 32'(accepted), 32'd1);
    if (accepted && record) begin
      e.q = eq;
      e.r = er;
      e.err = ee;
      sb.push_back(e);
    end
  endtask

  task automatic wait_outputs(input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (out_count >= target) break;
      @(negedge clk);
      #1;
    end
    check_output(name, 32'(out_count), 32'(target));
  endtask

  logic [31:0] t2_l [5] = '{32'h10000000, 32'h40000000, 32'h30000000, 32'h00000001, 32'h08000000};
  logic [31:0] t2_r [5] = '{32'h40000000, 32'h40000000, 32'h60000000, 32'h00000003, 32'h20000000};
  logic [31:0] t2_q [5] = '{32'h20000000, 32'h80000000, 32'h40000000, 32'h2AAAAAAA, 32'h20000000};
  logic [31:0] t2_rm[5] = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h0};

  initial begin
    int g0;
    int base;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_left    = '0;
    in_right   = '0;
    out_ready  = 1'b1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_count", 32'(count), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_div_go", 32'(div_go), 32'd0);
    check_output("reset_quotient", out_quotient, 32'h0);
    check_output("reset_remainder", out_remainder, 32'h0);
    check_output("reset_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single 0.25 / 0.5 operation.
    g0 = go_episodes;
    apply_stimulus(32'h20000000, 32'h40000000, 1'b1, 32'h40000000, 32'h0, 1'b0);
    wait_outputs(1, 60, "t1_output");
    @(negedge clk);
    check_output("t1_valid_one_cycle", 32'(out_valid), 32'd0);
    check_output("t1_go_episodes", 32'(go_episodes - g0), 32'd1);

    // Five back-to-back pushes into a four-entry FIFO.
    base = out_count;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(t2_l[k], t2_r[k], 1'b1, t2_q[k], t2_rm[k], 1'b0);
      if (k == 3) begin
        check_output("t2_in_ready_full", 32'(in_ready), 32'd0);
        check_output("t2_count_full", 32'(count), 32'd4);
      end
    end
    wait_outputs(base + 5, 300, "t2_outputs");

    // Zero dividend: done one cycle after go, result the cycle after that.
    repeat (3) @(negedge clk);
    base = out_count;
    apply_stimulus(32'h0, 32'h40000000, 1'b1, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_go) break;
    end
    check_output("t3_go_seen", 32'(div_go), 32'd1);
    @(negedge clk);
    check_output("t3_done_next", 32'(div_done), 32'd1);
    check_output("t3_go_dropped", 32'(div_go), 32'd0);
    check_output("t3_valid_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("t3_valid_go_plus_2", 32'(out_valid), 32'd1);
    wait_outputs(base + 1, 20, "t3_output");

    // Output stalled with two queued operations.
    out_ready = 1'b0;
    g0 = go_episodes;
    base = out_count;
    apply_stimulus(32'h10000000, 32'h80000000, 1'b1, 32'h10000000, 32'h0, 1'b0);
    apply_stimulus(32'h20000000, 32'h20000000, 1'b1, 32'h80000000, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check_output("t4_first_valid", 32'(out_valid), 32'd1);
    repeat (8) @(negedge clk);
    check_output("t4_no_second_go", 32'(go_episodes - g0), 32'd1);
    check_output("t4_still_valid", 32'(out_valid), 32'd1);
    check_output("t4_held_quotient", out_quotient, 32'h10000000);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_output("t4_second_issue", 32'(div_go), 32'd1);
    out_ready = 1'b1;
    wait_outputs(base + 2, 60, "t4_outputs");

    // Reset in the middle of a RUN with three entries queued.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) apply_stimulus(32'h20000000, 32'h40000000, 1'b0, 32'h0, 32'h0, 1'b0);
    check_output("t5_queued", 32'(count), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check_output("t5_go_in_reset", 32'(div_go), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("t5_count_cleared", 32'(count), 32'd0);
    check_output("t5_valid_cleared", 32'(out_valid), 32'd0);
    base = out_count;
    @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check_output("t5_no_stray_capture", 32'(out_valid), 32'd0);
    check_output("t5_no_stray_output", 32'(out_count), 32'(base));

    // Zero divisor.
    g0 = go_episodes;
    base = out_count;
`ifdef FP_DIV_ZERO_CHK_EN
    apply_stimulus(32'h12345678, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    wait_outputs(base + 1, 60, "t6_output");
    check_output("t6_go_episodes", 32'(go_episodes - g0), 32'd0);
`else
    apply_stimulus(32'h12345678, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
    wait_outputs(base + 1, 60, "t6_output");
    check_output("t6_go_episodes", 32'(go_episodes - g0), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    check_output("max_count", 32'(max_count), 32'd4);
    check_output("operand_stability", 32'(stab_err), 32'd0);
    check_output("held_result_stability", 32'(hold_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
